// File: rtl/phase_pkg.sv
// phase_pkg: shared widths, FSM encoding, saturation limits and W-bit saturating helper for sweep_diff_gen
package phase_pkg;
  localparam int W = 16;
  localparam int N_ROOTS = 4;
  localparam int IDX_W = 2;
  localparam logic signed [W-1:0] SAT_MAX = 16'sh7fff;
  localparam logic signed [W-1:0] SAT_MIN = 16'sh8000;
  typedef enum logic [1:0] {IDLE, CALC, PRES, FIN} state_t;
  function automatic logic signed [W-1:0] sat_w(input logic signed [W:0] v);
    return (v[W] != v[W-1]) ? (v[W] ? SAT_MIN : SAT_MAX) : v[W-1:0];
  endfunction
endpackage

// File: rtl/sat_sub.sv
// sat_sub: combinational y = sat(a - b), computed at W+1 bits; ports a, b (signed W) -> y (signed W)
module sat_sub
  import phase_pkg::*;
(
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);
  assign y = sat_w({a[W-1], a} - {b[W-1], b});
endmodule

// File: rtl/sweep_diff_gen.sv
// sweep_diff_gen: j*omega sweep emitting packed saturated (s - root) diffs for 4 zeros/4 poles; ports clk/rst_n, cfg_* table writes, start/omega_start/omega_step/n_points, out_valid/out_ready with diff buses and point_idx, busy, done; LOG_SWEEP_EN selects geometric stepping
module sweep_diff_gen
  import phase_pkg::*;
#(
  parameter int PTS_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic                   cfg_pole,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [W-1:0]           cfg_re,
  input  logic [W-1:0]           cfg_im,
  input  logic                   start,
  input  logic [W-1:0]           omega_start,
  input  logic [W-1:0]           omega_step,
  input  logic [PTS_W-1:0]       n_points,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [N_ROOTS*W-1:0]   zero_diff_re,
  output logic [N_ROOTS*W-1:0]   zero_diff_im,
  output logic [N_ROOTS*W-1:0]   pole_diff_re,
  output logic [N_ROOTS*W-1:0]   pole_diff_im,
  output logic [PTS_W-1:0]       point_idx,
  output logic                   busy,
  output logic                   done
);
  state_t state_q, state_d;
  logic signed [W-1:0] z_re [N_ROOTS];
  logic signed [W-1:0] z_im [N_ROOTS];
  logic signed [W-1:0] p_re [N_ROOTS];
  logic signed [W-1:0] p_im [N_ROOTS];
  logic signed [W-1:0] omega, step, omega_nx;
  logic [PTS_W-1:0] npts;
  logic [N_ROOTS*W-1:0] zre_d, zim_d, pre_d, pim_d;
  logic last, hs;
  assign out_valid = state_q == PRES;
  assign busy = state_q == CALC || state_q == PRES;
  assign done = state_q == FIN;
  assign last = point_idx == npts - 1'b1;
  assign hs = out_valid && out_ready;
  for (genvar i = 0; i < N_ROOTS; i++) begin : g_lane
    sat_sub u_zre (.a('0),    .b(z_re[i]), .y(zre_d[i*W +: W]));
    sat_sub u_zim (.a(omega), .b(z_im[i]), .y(zim_d[i*W +: W]));
    sat_sub u_pre (.a('0),    .b(p_re[i]), .y(pre_d[i*W +: W]));
    sat_sub u_pim (.a(omega), .b(p_im[i]), .y(pim_d[i*W +: W]));
  end
`ifdef LOG_SWEEP_EN
  logic [3:0] k;
  logic signed [W-1:0] sh, inc;
  assign k = step[3:0] == 4'd0 ? 4'd1 : step[3:0];
  assign sh = omega >>> k;
  assign inc = (sh[W-1] || sh == '0) ? W'(1) : sh;
  assign omega_nx = sat_w({omega[W-1], omega} + {inc[W-1], inc});
`else
  assign omega_nx = sat_w({omega[W-1], omega} + {step[W-1], step});
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = n_points == '0 ? FIN : CALC;
      CALC: state_d = PRES;
      PRES: if (out_ready) state_d = last ? FIN : CALC;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      omega <= '0;
      step <= '0;
      npts <= '0;
      point_idx <= '0;
      zero_diff_re <= '0;
      zero_diff_im <= '0;
      pole_diff_re <= '0;
      pole_diff_im <= '0;
      for (int j = 0; j < N_ROOTS; j++) begin
        z_re[j] <= '0;
        z_im[j] <= '0;
        p_re[j] <= '0;
        p_im[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (cfg_we && state_q == IDLE) begin
        if (cfg_pole) begin
          p_re[cfg_idx] <= cfg_re;
          p_im[cfg_idx] <= cfg_im;
        end else begin
          z_re[cfg_idx] <= cfg_re;
          z_im[cfg_idx] <= cfg_im;
        end
      end
      if (start && state_q == IDLE) begin
        omega <= omega_start;
        step <= omega_step;
        npts <= n_points;
        point_idx <= '0;
      end
      if (state_q == CALC) begin
        zero_diff_re <= zre_d;
        zero_diff_im <= zim_d;
        pole_diff_re <= pre_d;
        pole_diff_im <= pim_d;
      end
      if (hs && !last) begin
        omega <= omega_nx;
        point_idx <= point_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sweep_diff_gen.sv
// tb_sweep_diff_gen: scoreboard bench for sweep_diff_gen covering reset, sweeps, backpressure, saturation, ignored inputs and abort
module tb_sweep_diff_gen;
  localparam int PTS_W = 10;
  typedef struct {
    int idx;
    logic [63:0] zre, zim, pre, pim;
  } exp_t;
  logic clk = 0, rst_n = 0;
  logic cfg_we = 0, cfg_pole = 0, start = 0, out_ready = 1;
  logic [1:0] cfg_idx = 0;
  logic [15:0] cfg_re = 0, cfg_im = 0, omega_start = 0, omega_step = 0;
  logic [PTS_W-1:0] n_points = 0;
  logic out_valid, busy, done;
  logic [63:0] zero_diff_re, zero_diff_im, pole_diff_re, pole_diff_im;
  logic [PTS_W-1:0] point_idx;
  exp_t q[$];
  int acc_im0[$];
  int tz_re[4], tz_im[4], tp_re[4], tp_im[4];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  sweep_diff_gen #(.PTS_W(PTS_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pole(cfg_pole), .cfg_idx(cfg_idx),
    .cfg_re(cfg_re), .cfg_im(cfg_im), .start(start), .omega_start(omega_start),
    .omega_step(omega_step), .n_points(n_points), .out_ready(out_ready), .out_valid(out_valid),
    .zero_diff_re(zero_diff_re), .zero_diff_im(zero_diff_im), .pole_diff_re(pole_diff_re),
    .pole_diff_im(pole_diff_im), .point_idx(point_idx), .busy(busy), .done(done)
  );
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic int sat16(int v);
    return v > 32767 ? 32767 : (v < -32768 ? -32768 : v);
  endfunction
  function automatic int next_om(int om, int st);
`ifdef LOG_SWEEP_EN
    int k;
    int inc;
    k = st & 15;
    if (k == 0) k = 1;
    inc = om >>> k;
    if (inc < 1) inc = 1;
    return sat16(om + inc);
`else
    return sat16(om + st);
`endif
  endfunction
  function automatic exp_t make_exp(int p, int om);
    exp_t e;
    e.idx = p;
    for (int i = 0; i < 4; i++) begin
      e.zre[i*16 +: 16] = 16'(sat16(-tz_re[i]));
      e.zim[i*16 +: 16] = 16'(sat16(om - tz_im[i]));
      e.pre[i*16 +: 16] = 16'(sat16(-tp_re[i]));
      e.pim[i*16 +: 16] = 16'(sat16(om - tp_im[i]));
    end
    return e;
  endfunction
  task automatic cfg(input bit pole, input int idx, input int re, input int im);
    @(negedge clk);
    cfg_we = 1; cfg_pole = pole; cfg_idx = 2'(idx); cfg_re = 16'(re); cfg_im = 16'(im);
    @(negedge clk);
    cfg_we = 0;
    if (pole) begin tp_re[idx] = re; tp_im[idx] = im; end
    else begin tz_re[idx] = re; tz_im[idx] = im; end
  endtask
  task automatic run_sweep(input int os, input int st, input int n, input int stall_pt, input int stall_n, input int poke);
    int om, cyc, stalls, since, first_cyc;
    bit fin;
    logic [63:0] snap_zi, snap_pr;
    int snap_idx;
    om = os; cyc = 0; stalls = 0; since = -1; first_cyc = -1; fin = 0;
    snap_zi = 0; snap_pr = 0; snap_idx = 0;
    acc_im0.delete();
    for (int p = 0; p < n; p++) begin
      q.push_back(make_exp(p, om));
      om = next_om(om, st);
    end
    @(negedge clk);
    start = 1; omega_start = 16'(os); omega_step = 16'(st); n_points = PTS_W'(n); out_ready = 1;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 0; cfg_we = 0;
      if (cyc == poke) begin
        start = 1; omega_start = 16'd9999; n_points = 10'd7;
        cfg_we = 1; cfg_pole = 0; cfg_idx = 0; cfg_re = 16'd1234; cfg_im = 16'd1234;
      end
      if (since >= 0) since++;
      if (done) begin
        fin = 1;
        total++;
        if (since != 1 || q.size() != 0) begin
          bad++;
          $display("FAIL done_timing: since_last_accept=%0d pending=%0d, required 1 and 0", since, q.size());
        end
      end else if (out_valid) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          total++;
          if (cyc != 2) begin bad++; $display("FAIL first_latency: got %0d cycles, required 2", cyc); end
        end
        if (int'(point_idx) == stall_pt && stalls < stall_n) begin
          if (stalls == 0) begin
            snap_zi = zero_diff_im; snap_pr = pole_diff_re; snap_idx = int'(point_idx);
          end else begin
            total++;
            if (zero_diff_im !== snap_zi || pole_diff_re !== snap_pr || int'(point_idx) != snap_idx) begin
              bad++;
              $display("FAIL hold: idx=%0d zim=%h pre=%h, required idx=%0d zim=%h pre=%h", point_idx, zero_diff_im, pole_diff_re, snap_idx, snap_zi, snap_pr);
            end
          end
          stalls++;
          out_ready = 0;
        end else begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL extra_point: idx=%0d presented, required none", point_idx);
          end else begin
            exp_t e;
            e = q.pop_front();
            if (int'(point_idx) != e.idx || zero_diff_re !== e.zre || zero_diff_im !== e.zim || pole_diff_re !== e.pre || pole_diff_im !== e.pim) begin
              bad++;
              $display("FAIL point: idx=%0d zre=%h zim=%h pre=%h pim=%h, required idx=%0d zre=%h zim=%h pre=%h pim=%h",
                point_idx, zero_diff_re, zero_diff_im, pole_diff_re, pole_diff_im, e.idx, e.zre, e.zim, e.pre, e.pim);
            end
          end
          acc_im0.push_back(int'($signed(zero_diff_im[15:0])));
          out_ready = 1;
          since = 0;
        end
      end
    end
    if (!fin) begin total++; bad++; $display("FAIL sweep_timeout: no done after %0d cycles, required done", cyc); end
    out_ready = 1;
    q.delete();
  endtask
  task automatic test_reset();
    rst_n = 0;
    #23;
    total++;
    if ({out_valid, busy, done} !== 3'b000 || point_idx !== '0 || zero_diff_re !== '0 || zero_diff_im !== '0 || pole_diff_re !== '0 || pole_diff_im !== '0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b busy=%b done=%b idx=%0d, required all 0", out_valid, busy, done, point_idx);
    end
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_linear();
    int exp_im[4];
    cfg(0, 0, 0, 100); cfg(0, 1, 0, -100); cfg(0, 2, 50, 0); cfg(0, 3, -50, 0);
    for (int i = 0; i < 4; i++) cfg(1, i, -10, 0);
    run_sweep(0, 64, 4, -1, 0, -1);
    exp_im = '{-100, -36, 28, 92};
`ifndef LOG_SWEEP_EN
    for (int i = 0; i < 4; i++) begin
      total++;
      if (acc_im0.size() <= i || acc_im0[i] != exp_im[i]) begin
        bad++;
        $display("FAIL linear_im0[%0d]: got %0d, required %0d", i, acc_im0.size() > i ? acc_im0[i] : 0, exp_im[i]);
      end
    end
`endif
  endtask
  task automatic test_backpressure();
    run_sweep(0, 64, 4, 1, 5, -1);
  endtask
  task automatic test_saturation();
    cfg(0, 0, -32768, -32768);
    run_sweep(32000, 1000, 3, -1, 0, -1);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (acc_im0.size() <= i || acc_im0[i] != 32767) begin
        bad++;
        $display("FAIL sat_im0[%0d]: got %0d, required 32767", i, acc_im0.size() > i ? acc_im0[i] : 0);
      end
    end
  endtask
  task automatic test_zero_points();
    @(negedge clk);
    start = 1; n_points = 0; omega_start = 16'd5;
    @(negedge clk);
    start = 0;
    total++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_pts_fin: done=%b valid=%b busy=%b, required 1 0 0", done, out_valid, busy);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL zero_pts_after: done=%b valid=%b, required 0 0", done, out_valid);
    end
  endtask
  task automatic test_ignored();
    run_sweep(0, 64, 3, -1, 0, 1);
    run_sweep(500, 1, 2, -1, 0, -1);
  endtask
  task automatic test_reset_mid();
    int cyc;
    bit hit, saw_done;
    @(negedge clk);
    start = 1; omega_start = 16'd0; omega_step = 16'd64; n_points = 10'd4; out_ready = 1;
    cyc = 0; hit = 0;
    while (!hit && cyc < 40) begin
      @(negedge clk);
      start = 0;
      cyc++;
      if (out_valid && point_idx == 10'd2) hit = 1;
    end
    total++;
    if (!hit) begin bad++; $display("FAIL mid_reach: point 2 not presented, required presented"); end
    rst_n = 0;
    #1;
    total++;
    if ({out_valid, busy, done} !== 3'b000 || point_idx !== '0 || zero_diff_im !== '0 || pole_diff_re !== '0) begin
      bad++;
      $display("FAIL mid_reset: valid=%b busy=%b done=%b idx=%0d, required all 0", out_valid, busy, done, point_idx);
    end
    for (int i = 0; i < 4; i++) begin tz_re[i] = 0; tz_im[i] = 0; tp_re[i] = 0; tp_im[i] = 0; end
    @(negedge clk);
    rst_n = 1;
    saw_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || out_valid) saw_done = 1;
    end
    total++;
    if (saw_done) begin bad++; $display("FAIL mid_no_done: activity after abort, required none"); end
    cfg(0, 1, 7, -7);
    cfg(1, 3, 300, 20);
    run_sweep(100, 10, 3, -1, 0, -1);
  endtask
`ifdef LOG_SWEEP_EN
  task automatic test_log();
    int exp_om[3];
    cfg(0, 0, 0, 0);
    run_sweep(1024, 2, 3, -1, 0, -1);
    exp_om = '{1024, 1280, 1600};
    for (int i = 0; i < 3; i++) begin
      total++;
      if (acc_im0.size() <= i || acc_im0[i] != exp_om[i]) begin
        bad++;
        $display("FAIL log_omega[%0d]: got %0d, required %0d", i, acc_im0.size() > i ? acc_im0[i] : 0, exp_om[i]);
      end
    end
  endtask
`endif
  initial begin
    for (int i = 0; i < 4; i++) begin tz_re[i] = 0; tz_im[i] = 0; tp_re[i] = 0; tp_im[i] = 0; end
    test_reset();
    test_linear();
    test_backpressure();
    test_saturation();
    test_zero_points();
    test_ignored();
    test_reset_mid();
`ifdef LOG_SWEEP_EN
    test_log();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sweep_diff_gen.md
Name: sweep_diff_gen

Overview:
- Frequency-sweep front end that sits directly upstream of the phase evaluator.
- Stores 4 zero and 4 pole coordinates in Q-format 16-bit signed.
- Steps an angular frequency omega across a sweep. For each point it emits the packed difference vectors (s - root), with s = j*omega: diff_re = -root_re, diff_im = omega - root_im.
- Outputs use a valid/ready handshake and feed the phase evaluator's four 64-bit buses. One sweep point is presented at a time.

Parameters:
- W, 16, coordinate/omega width (signed).
- N_ROOTS, 4, zeros and poles per set; fixes bus width at N_ROOTS*W.
- PTS_W, 10, width of the point counter (maximum 1023 points).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  root-table write strobe
- cfg_pole  in  1  0 = zero table, 1 = pole table
- cfg_idx  in  2  root index 0..3
- cfg_re  in  W  root real part
- cfg_im  in  W  root imaginary part
- start  in  1  one-cycle sweep start pulse
- omega_start  in  W  first omega (signed, >= 0 expected)
- omega_step  in  W  linear increment per point
- n_points  in  PTS_W  points in sweep
- out_ready  in  1  downstream accepts point
- out_valid  out  1  point valid
- zero_diff_re  out  N_ROOTS*W  {d3,d2,d1,d0}, d0 in [15:0]
- zero_diff_im  out  N_ROOTS*W  same packing
- pole_diff_re  out  N_ROOTS*W  same packing
- pole_diff_im  out  N_ROOTS*W  same packing
- point_idx  out  PTS_W  index of the presented point
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse after the last point is accepted

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset values: all outputs 0, root tables 0, FSM in IDLE.
- FSM states and transitions:
  - IDLE: on start, latch omega_start, omega_step and n_points.
    - If n_points = 0, go to FIN.
    - Otherwise go to CALC with point_idx = 0 and busy = 1.
  - CALC: compute and register all 16 differences from the current omega, then go to PRES.
  - PRES: out_valid = 1; outputs are held stable while out_valid && !out_ready.
    - On handshake, if point_idx = n_points-1, go to FIN.
    - Otherwise advance omega, increment point_idx and go to CALC.
  - FIN: done = 1 for one cycle, busy = 0, then go to IDLE.
- Latency: start to first out_valid is 2 cycles. Throughput is 1 point per 2 cycles at best.
- Arithmetic:
  - diff_re = sat(-root_re), so -32768 becomes 32767.
  - diff_im = sat(omega - root_im), computed at W+1 bits and saturated to [-32768, 32767].
  - omega_next = sat(omega + omega_step), saturating at 32767. The sweep continues at the clamp value and does not wrap.
- Config:
  - cfg_we is accepted only in IDLE; it is ignored while busy.
  - A write in the same cycle as start is applied, and the sweep uses the new value.
- start outside IDLE is ignored.
- out_ready while out_valid = 0 has no effect.
- Reset mid-sweep aborts immediately: out_valid drops and no done pulse is produced.

Optional Feature:
- Macro LOG_SWEEP_EN.
- Defined: omega_step[3:0] is reinterpreted as shift k (1..15; 0 is treated as 1), and omega_next = sat(omega + max(omega >> k, 1)). This gives a geometric sweep of ratio about 1 + 2^-k. The upper bits of omega_step are ignored.
- Undefined: linear stepping as described in Behaviour.

Decomposition:
- Shared package phase_pkg holds:
  - W and N_ROOTS constants
  - root-index width
  - FSM state encoding (IDLE/CALC/PRES/FIN)
  - saturation limits SAT_MAX/SAT_MIN
- One natural sub-module, sat_sub: a combinational (W+1)-bit subtract with saturation to W bits, instantiated per diff_im lane. The negation for diff_re uses a = 0.

Test Plan:
- Linear sweep:
  - Stimulus: zeros (0,100),(0,-100),(50,0),(-50,0); poles all (-10,0); start with omega_start=0, step=64, n_points=4, out_ready=1.
  - Response: 4 points with omega 0/64/128/192. zero_diff_im lane0 = -100,-36,28,92. pole_diff_re all 10. done one cycle after the 4th handshake.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles on point 1.
  - Response: buses and point_idx stay constant and out_valid stays 1. There is no skipped or duplicated point_idx.
- Saturation:
  - Stimulus: root_re=-32768, root_im=-32768, omega_start=32000, step=1000, n=3.
  - Response: diff_re = 32767; diff_im clamps at 32767 on all points; omega stays at 32767 and does not wrap.
- Boundary and ignored inputs:
  - Stimulus: n_points=0.
  - Response: no out_valid, and done 1 cycle after FIN entry.
  - Stimulus: start pulsed while busy.
  - Response: ignored.
  - Stimulus: cfg_we while busy.
  - Response: the table is unchanged, checked by readback through the next sweep.
- Reset mid-sweep:
  - Stimulus: assert rst_n=0 during PRES of point 2.
  - Response: all outputs 0 asynchronously; no done; the next sweep starts cleanly from point_idx 0.
- LOG_SWEEP_EN build:
  - Stimulus: omega_start=1024, step k=2, n=3.
  - Response: omega 1024, 1280, 1600.
